// File: rtl/pipe_scroller.sv
// Single-pipe obstacle generator: spawns a pipe at the right edge with an LFSR-chosen gap
// centre, scrolls it left once per frame tick and pulses score_pulse as it clears the bird.
module pipe_scroller #(
  parameter int unsigned SCREEN_WIDTH = 640,
  parameter int unsigned PIPE_WIDTH   = 70,
  parameter int unsigned GAP_HEIGHT   = 120,
  parameter int unsigned GAP_MIN      = 100,
  parameter int unsigned GAP_MAX      = 380,
  parameter int unsigned BIRD_X       = 160,
  parameter int unsigned SPAWN_DELAY  = 60,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        enable,
  input  logic        restart,
  input  logic [3:0]  speed,
  output logic [31:0] pipe_reg,
  output logic        score_pulse,
  output logic        pipe_active
);

  localparam logic [9:0]  EdgeSpawn = 10'(SCREEN_WIDTH);
  localparam logic [8:0]  HeightVal = 9'(GAP_HEIGHT);
  localparam logic [8:0]  GapMinVal = 9'(GAP_MIN);
  localparam logic [8:0]  GapSpan   = 9'(GAP_MAX - GAP_MIN);
  localparam logic [8:0]  GapRange  = 9'(GAP_MAX - GAP_MIN + 1);
  localparam logic [10:0] PipeW     = 11'(PIPE_WIDTH);
  localparam logic [10:0] BirdCol   = 11'(BIRD_X);
  localparam logic [7:0]  DelayVal  = 8'(SPAWN_DELAY);

  typedef enum logic [1:0] {StIdle, StWait, StScroll} state_e;

  state_e      state_q, state_d;
  logic [9:0]  edge_q, edge_d;
  logic [8:0]  centre_q, centre_d;
  logic [8:0]  height_q, height_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        score_q, score_d;
  logic        active_q, active_d;
  logic [15:0] lfsr_q;

  logic        tick;
  logic [8:0]  rnd;
  logic [8:0]  gap_off;
  logic [10:0] edge_ext;
  logic [10:0] speed_ext;
  logic [10:0] edge_next;

  assign tick      = frame_tick & enable;
  assign rnd       = lfsr_q[8:0];
  // Fold the 9-bit random value back into the legal gap range with one subtraction.
  assign gap_off   = (rnd > GapSpan) ? (rnd - GapRange) : rnd;
  assign edge_ext  = {1'b0, edge_q};
  assign speed_ext = {7'd0, speed};
  assign edge_next = edge_ext - speed_ext;

  // Free-running regardless of enable/restart so spawns stay unpredictable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      edge_q   <= '0;
      centre_q <= '0;
      height_q <= '0;
      cnt_q    <= '0;
      score_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      centre_q <= centre_d;
      height_q <= height_d;
      cnt_q    <= cnt_d;
      score_q  <= score_d;
      active_q <= active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    edge_d   = edge_q;
    centre_d = centre_q;
    height_d = height_q;
    cnt_d    = cnt_q;
    score_d  = 1'b0;

    if (restart) begin
      state_d  = StIdle;
      edge_d   = '0;
      centre_d = '0;
      height_d = '0;
      cnt_d    = '0;
    end else if (tick) begin
      case (state_q)
        StIdle: begin
          cnt_d   = DelayVal;
          state_d = StWait;
        end
        StWait: begin
          if (cnt_q == 8'd0) begin
            edge_d   = EdgeSpawn;
            centre_d = GapMinVal + gap_off;
            height_d = HeightVal;
            state_d  = StScroll;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StScroll: begin
          if (edge_ext < speed_ext) begin
            edge_d   = '0;
            centre_d = '0;
            height_d = '0;
            cnt_d    = DelayVal;
            state_d  = StWait;
          end else begin
            edge_d  = edge_next[9:0];
            // Right edge crosses the bird column on this move.
            score_d = ((edge_ext + PipeW) >= BirdCol) && ((edge_next + PipeW) < BirdCol);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    active_d = (state_d == StScroll);
  end

  always_comb begin
    pipe_reg    = {4'd0, height_q, centre_q, edge_q};
    score_pulse = score_q;
    pipe_active = active_q;
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: behavioural model compared every cycle plus
// directed literal expectations for spawn, scroll, scoring, gap bounds, freeze and resets.
module tb_pipe_scroller;

  localparam int          SD   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        enable;
  logic        restart;
  logic [3:0]  speed;
  logic [31:0] pipe_reg;
  logic        score_pulse;
  logic        pipe_active;

  int n_checks = 0;
  int n_errors = 0;

  pipe_scroller #(
    .SCREEN_WIDTH(640),
    .PIPE_WIDTH  (70),
    .GAP_HEIGHT  (120),
    .GAP_MIN     (100),
    .GAP_MAX     (380),
    .BIRD_X      (160),
    .SPAWN_DELAY (SD),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .restart    (restart),
    .speed      (speed),
    .pipe_reg   (pipe_reg),
    .score_pulse(score_pulse),
    .pipe_active(pipe_active)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_phase;  // 0 idle, 1 wait, 2 scroll
  int          m_edge;
  int          m_centre;
  int          m_cnt;
  bit          m_score;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] next_lfsr(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or posedge reset) begin : model_blk
    int ph, ed, ce, cn, r, s;
    bit sc;
    if (reset) begin
      m_phase  <= 0;
      m_edge   <= 0;
      m_centre <= 0;
      m_cnt    <= 0;
      m_score  <= 1'b0;
      m_lfsr   <= SEED;
    end else begin
      ph = m_phase;
      ed = m_edge;
      ce = m_centre;
      cn = m_cnt;
      s  = int'(speed);
      sc = 1'b0;
      if (restart) begin
        ph = 0; ed = 0; ce = 0; cn = 0;
      end else if (frame_tick && enable) begin
        if (ph == 0) begin
          cn = SD; ph = 1;
        end else if (ph == 1) begin
          if (cn == 0) begin
            r  = int'(m_lfsr[8:0]);
            ce = 100 + ((r > 280) ? r - 281 : r);
            ed = 640;
            ph = 2;
          end else begin
            cn = cn - 1;
          end
        end else begin
          if (ed < s) begin
            ph = 1; cn = SD; ed = 0; ce = 0;
          end else begin
            sc = (ed + 70 >= 160) && (ed - s + 70 < 160);
            ed = ed - s;
          end
        end
      end
      m_phase  <= ph;
      m_edge   <= ed;
      m_centre <= ce;
      m_cnt    <= cn;
      m_score  <= sc;
      m_lfsr   <= next_lfsr(m_lfsr);
    end
  end

  function automatic logic [31:0] model_word();
    if (m_phase == 2) return {4'd0, 9'd120, 9'(m_centre), 10'(m_edge)};
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    logic [31:0] w;
    w = model_word();
    n_checks++;
    if (pipe_reg !== w || score_pulse !== m_score || pipe_active !== (m_phase == 2)) begin
      n_errors++;
      if (n_errors < 40)
        $display("FAIL model t=%0t pipe_reg got %h want %h, score got %b want %b, active got %b want %b",
                 $time, pipe_reg, w, score_pulse, m_score, pipe_active, (m_phase == 2));
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  // Restart, walk to WAIT with delay 0, then tick on the cycle whose LFSR low bits match.
  task automatic spawn_with(input logic [8:0] target, input int exp_centre, input string name);
    int waited;
    do_restart();
    repeat (SD + 1) do_tick();
    waited = 0;
    @(negedge clk);
    while (m_lfsr[8:0] != target && waited < 15000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 15000) begin
      check({name, "_timeout"}, 32'(waited), 32'd0);
    end else begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      check(name, 32'(pipe_reg[18:10]), 32'(exp_centre));
      check({name, "_edge"}, 32'(pipe_reg[9:0]), 32'd640);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int pulses, pulse_edge, exit_ticks, sc_seen;
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b1; restart = 1'b0; speed = 4'd5;
    repeat (3) @(negedge clk);
    check("reset_pipe_reg", pipe_reg, 32'd0);
    check("reset_score", 32'(score_pulse), 32'd0);
    check("reset_active", 32'(pipe_active), 32'd0);
    check("reset_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    reset = 1'b0;

    // Idle to first pipe: 1 + (SD+1) ticks.
    for (int i = 1; i <= 3; i++) begin
      do_tick();
      check("pre_spawn_zero", pipe_reg, 32'd0);
    end
    do_tick();
    check("spawn_edge", 32'(pipe_reg[9:0]), 32'd640);
    check("spawn_height", 32'(pipe_reg[27:19]), 32'd120);
    check("spawn_centre_in_range",
          32'(pipe_reg[18:10] >= 9'd100 && pipe_reg[18:10] <= 9'd380), 32'd1);
    check("spawn_active", 32'(pipe_active), 32'd1);

    do_tick();
    check("first_scroll_edge", 32'(pipe_reg[9:0]), 32'd635);

    // Scroll to exit; right edge 160 -> 155 is the crossing, i.e. left edge 90 -> 85.
    pulses = 0; pulse_edge = -1; exit_ticks = 0;
    while (pipe_active && exit_ticks < 200) begin
      do_tick();
      exit_ticks++;
      if (score_pulse) begin
        pulses++;
        pulse_edge = int'(pipe_reg[9:0]);
      end
    end
    check("score_pulse_count", 32'(pulses), 32'd1);
    check("score_pulse_edge", 32'(pulse_edge), 32'd85);
    check("exit_tick_count", 32'(exit_ticks), 32'd128);
    check("exit_pipe_reg", pipe_reg, 32'd0);

    // Gap centre fold at the range boundaries.
    spawn_with(9'd0,   100, "centre_r0");
    spawn_with(9'd280, 380, "centre_r280");
    spawn_with(9'd281, 100, "centre_r281");
    spawn_with(9'd511, 330, "centre_r511");

    // Speed 0 keeps the pipe parked.
    speed = 4'd0;
    repeat (3) do_tick();
    check("speed0_edge", 32'(pipe_reg[9:0]), 32'd640);
    speed = 4'd5;

    repeat (48) do_tick();
    check("freeze_start_edge", 32'(pipe_reg[9:0]), 32'd400);
    enable = 1'b0;
    sc_seen = 0;
    for (int i = 0; i < 10; i++) begin
      do_tick();
      if (score_pulse) sc_seen++;
    end
    check("freeze_edge", 32'(pipe_reg[9:0]), 32'd400);
    check("freeze_no_score", 32'(sc_seen), 32'd0);
    enable = 1'b1;
    do_tick();
    check("unfreeze_edge", 32'(pipe_reg[9:0]), 32'd395);

    // Restart wins over a simultaneous tick.
    @(negedge clk);
    restart = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0; frame_tick = 1'b0;
    check("restart_pipe_reg", pipe_reg, 32'd0);
    check("restart_active", 32'(pipe_active), 32'd0);
    check("restart_score", 32'(score_pulse), 32'd0);
    repeat (SD + 1) do_tick();
    check("restart_idle_then_wait", pipe_reg, 32'd0);
    do_tick();
    check("respawn_edge", 32'(pipe_reg[9:0]), 32'd640);
    repeat (4) do_tick();

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pipe_reg", pipe_reg, 32'd0);
    check("async_reset_active", 32'(pipe_active), 32'd0);
    check("async_reset_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_tick();
    check("post_reset_tick1", pipe_reg, 32'd0);
    repeat (SD + 1) do_tick();
    check("post_reset_spawn", 32'(pipe_reg[9:0]), 32'd640);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
